// File: rtl/alu_seq.sv
// Sequential ALU with a valid/ready request and result handshake.
// Mul/Div iterate one bit per cycle on operand magnitudes; signs are fixed up in a final cycle.
module alu_seq #(
  parameter int Width = 32
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [2:0]           opcode_i,
  input  logic                 signed_i,
  input  logic [Width-1:0]     operand_a_i,
  input  logic [Width-1:0]     operand_b_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [2*Width-1:0]   result_o,
  output logic                 divzero_o,
  output logic                 illegal_o
);

  localparam int CntW = $clog2(Width + 1);
  localparam logic [2:0] OpAdd = 3'd1;
  localparam logic [2:0] OpSub = 3'd2;
  localparam logic [2:0] OpMul = 3'd3;
  localparam logic [2:0] OpDiv = 3'd4;

  typedef enum logic [1:0] {Idle, Busy, Done} state_t;
  state_t state, state_next;

  logic [2:0]         op_q;
  logic               sgn_q;
  logic [Width-1:0]   a_q, b_q, b_mag_q;
  logic [2*Width-1:0] acc_q;
  logic [CntW-1:0]    cnt_q;
  logic [2*Width-1:0] result_q;
  logic               divzero_q, illegal_q;

  logic               accept;
  logic [Width-1:0]   a_mag_in, b_mag_in;
  logic               iterative_in;
  logic [Width:0]     mul_sum, div_trial, div_diff;
  logic [2*Width-1:0] acc_step;
  logic               a_neg, b_neg;
  logic [Width-1:0]   quo_fix, rem_fix;
  logic [2*Width-1:0] prod_fix, result_fin;

  assign accept = (state == Idle) && valid_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= Idle;
    else         state <= state_next;
  end

  // Every accepted op passes through Busy; single-cycle ops arrive there with a zero count.
  always_comb begin
    state_next = state;
    ready_o    = 1'b0;
    valid_o    = 1'b0;
    case (state)
      Idle: begin
        ready_o = 1'b1;
        if (valid_i) state_next = Busy;
      end
      Busy: begin
        if (cnt_q == '0) state_next = Done;
      end
      Done: begin
        valid_o = 1'b1;
        if (ready_i) state_next = Idle;
      end
      default: state_next = Idle;
    endcase
  end

  always_comb begin
    a_mag_in     = (signed_i && operand_a_i[Width-1]) ? -operand_a_i : operand_a_i;
    b_mag_in     = (signed_i && operand_b_i[Width-1]) ? -operand_b_i : operand_b_i;
    iterative_in = (opcode_i == OpMul) || ((opcode_i == OpDiv) && (operand_b_i != '0));
  end

  // acc holds {high, low}: product/multiplier for Mul, remainder/quotient for Div.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*Width-1:Width]} + (acc_q[0] ? {1'b0, b_mag_q} : '0);
    div_trial = {acc_q[2*Width-1:Width], acc_q[Width-1]};
    div_diff  = div_trial - {1'b0, b_mag_q};
    acc_step  = acc_q;
    if (op_q == OpMul)
      acc_step = {mul_sum, acc_q[Width-1:1]};
    else if (div_diff[Width])
      acc_step = {div_trial[Width-1:0], acc_q[Width-2:0], 1'b0};
    else
      acc_step = {div_diff[Width-1:0], acc_q[Width-2:0], 1'b1};
  end

  // Most-negative / -1 needs no special case: the negated magnitude wraps back to itself.
  always_comb begin
    a_neg    = sgn_q & a_q[Width-1];
    b_neg    = sgn_q & b_q[Width-1];
    prod_fix = (a_neg ^ b_neg) ? -acc_q : acc_q;
    quo_fix  = (a_neg ^ b_neg) ? -acc_q[Width-1:0] : acc_q[Width-1:0];
    rem_fix  = a_neg ? -acc_q[2*Width-1:Width] : acc_q[2*Width-1:Width];
    case (op_q)
      OpAdd:   result_fin = {{Width{1'b0}}, Width'(a_q + b_q)};
      OpSub:   result_fin = {{Width{1'b0}}, Width'(a_q - b_q)};
      OpMul:   result_fin = prod_fix;
      OpDiv:   result_fin = (b_q == '0) ? {a_q, {Width{1'b1}}} : {rem_fix, quo_fix};
      default: result_fin = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      op_q      <= '0;
      sgn_q     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      b_mag_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      divzero_q <= 1'b0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      op_q    <= opcode_i;
      sgn_q   <= signed_i;
      a_q     <= operand_a_i;
      b_q     <= operand_b_i;
      b_mag_q <= b_mag_in;
      acc_q   <= {{Width{1'b0}}, a_mag_in};
      cnt_q   <= iterative_in ? CntW'(Width) : '0;
    end else if (state == Busy) begin
      if (cnt_q != '0) begin
        acc_q <= acc_step;
        cnt_q <= cnt_q - CntW'(1);
      end else begin
        result_q  <= result_fin;
        divzero_q <= (op_q == OpDiv) && (b_q == '0);
        illegal_q <= (op_q > OpDiv);
      end
    end
  end

  assign result_o  = result_q;
  assign divzero_o = valid_o & divzero_q;
  assign illegal_o = valid_o & illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed Width=32 cases plus randomized Width=8 ops against an arithmetic model.
module tb_alu_seq;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        v32, rdy32, vo32, ri32, s32, dz32, il32;
  logic [2:0]  op32;
  logic [31:0] a32, b32;
  logic [63:0] res32;

  logic        v8, rdy8, vo8, ri8, s8, dz8, il8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8;
  logic [15:0] res8;

  int total = 0;
  int bad = 0;

  alu_seq #(.Width(32)) dut32 (
    .clk_i(clock), .reset_i(reset), .valid_i(v32), .ready_o(rdy32),
    .opcode_i(op32), .signed_i(s32), .operand_a_i(a32), .operand_b_i(b32),
    .valid_o(vo32), .ready_i(ri32), .result_o(res32),
    .divzero_o(dz32), .illegal_o(il32)
  );

  alu_seq #(.Width(8)) dut8 (
    .clk_i(clock), .reset_i(reset), .valid_i(v8), .ready_o(rdy8),
    .opcode_i(op8), .signed_i(s8), .operand_a_i(a8), .operand_b_i(b8),
    .valid_o(vo8), .ready_i(ri8), .result_o(res8),
    .divzero_o(dz8), .illegal_o(il8)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference semantics from plain integer arithmetic ('/' truncates, '%' follows dividend).
  function automatic void model8(input logic [2:0] op, input logic s, input logic [7:0] a,
                                 input logic [7:0] b, output logic [15:0] r,
                                 output logic dz, output logic il);
    longint sa = s ? longint'($signed(a)) : longint'(a);
    longint sb = s ? longint'($signed(b)) : longint'(b);
    r = '0; dz = 1'b0; il = 1'b0;
    case (op)
      3'd0: r = '0;
      3'd1: r = {8'h00, 8'(a + b)};
      3'd2: r = {8'h00, 8'(a - b)};
      3'd3: r = 16'(sa * sb);
      3'd4: begin
        if (b == 8'h00) begin
          r = {a, 8'hFF};
          dz = 1'b1;
        end else begin
          r = {8'(sa % sb), 8'(sa / sb)};
        end
      end
      default: il = 1'b1;
    endcase
  endfunction

  // Called #1 after an edge with the Width=32 DUT idle; issues one op and retires it.
  task automatic applyStimulus(input string tag, input logic [2:0] op, input logic s,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [63:0] er, input logic edz, input logic eil,
                               input int elat);
    int n;
    checkOutput({tag, "_ready"}, 64'(rdy32), 64'd1);
    v32 = 1'b1; op32 = op; s32 = s; a32 = a; b32 = b;
    @(posedge clock); #1;
    v32 = 1'b0; a32 = ~a; b32 = ~b; s32 = ~s;
    checkOutput({tag, "_ready_fall"}, 64'(rdy32), 64'd0);
    n = 0;
    while (!vo32 && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    checkOutput({tag, "_latency"}, 64'(n), 64'(elat));
    checkOutput({tag, "_result"}, res32, er);
    checkOutput({tag, "_divzero"}, 64'(dz32), 64'(edz));
    checkOutput({tag, "_illegal"}, 64'(il32), 64'(eil));
    ri32 = 1'b1;
    @(posedge clock); #1;
    ri32 = 1'b0;
    checkOutput({tag, "_retired"}, 64'({vo32, rdy32}), 64'b01);
  endtask

  task automatic applyStimulus8(input logic [2:0] op, input logic s,
                                input logic [7:0] a, input logic [7:0] b);
    int n;
    int elat;
    logic [15:0] er;
    logic edz, eil;
    model8(op, s, a, b, er, edz, eil);
    elat = (op == 3'd3 || (op == 3'd4 && b != 8'h00)) ? 9 : 1;
    v8 = 1'b1; op8 = op; s8 = s; a8 = a; b8 = b;
    @(posedge clock); #1;
    v8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); s8 = ~s;
    n = 0;
    while (!vo8 && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    checkOutput("w8_latency", 64'(n), 64'(elat));
    checkOutput("w8_result", 64'(res8), 64'(er));
    checkOutput("w8_flags", 64'({dz8, il8}), 64'({edz, eil}));
    ri8 = 1'b1;
    @(posedge clock); #1;
    ri8 = 1'b0;
    checkOutput("w8_retired", 64'({vo8, rdy8}), 64'b01);
  endtask

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 5))
      0: return 8'h00;
      1: return 8'h80;
      2: return 8'hFF;
      3: return 8'h01;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    int n;
    reset = 1'b1;
    v32 = 0; ri32 = 0; s32 = 0; op32 = 0; a32 = 0; b32 = 0;
    v8 = 0; ri8 = 0; s8 = 0; op8 = 0; a8 = 0; b8 = 0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_w32", {res32[31:0], 28'd0, rdy32, vo32, dz32, il32}, 64'h8);
    checkOutput("reset_hi_w32", 64'(res32[63:32]), 64'd0);
    checkOutput("reset_w8", {44'd0, res8, rdy8, vo8, dz8, il8}, 64'h8);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;

    applyStimulus("sdiv_m7_2",   3'd4, 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0, 1'b0, 33);
    applyStimulus("udiv_7_2",    3'd4, 1'b0, 32'd7, 32'd2, 64'h00000001_00000003, 1'b0, 1'b0, 33);
    applyStimulus("smul_m3_5",   3'd3, 1'b1, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, 1'b0, 1'b0, 33);
    applyStimulus("umul_max_2",  3'd3, 1'b0, 32'hFFFFFFFF, 32'd2, 64'h00000001_FFFFFFFE, 1'b0, 1'b0, 33);
    applyStimulus("add_wrap",    3'd1, 1'b0, 32'hFFFFFFFF, 32'd1, 64'h0, 1'b0, 1'b0, 1);
    applyStimulus("sub_3_5",     3'd2, 1'b1, 32'd3, 32'd5, 64'h00000000_FFFFFFFE, 1'b0, 1'b0, 1);
    applyStimulus("udiv_by0",    3'd4, 1'b0, 32'h12345678, 32'd0, 64'h12345678_FFFFFFFF, 1'b1, 1'b0, 1);
    applyStimulus("sdiv_by0",    3'd4, 1'b1, 32'hFFFFFFFB, 32'd0, 64'hFFFFFFFB_FFFFFFFF, 1'b1, 1'b0, 1);
    applyStimulus("sdiv_ovf",    3'd4, 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 1'b0, 33);
    applyStimulus("illegal_6",   3'd6, 1'b0, 32'd9, 32'd4, 64'h0, 1'b0, 1'b1, 1);
    applyStimulus("nop",         3'd0, 1'b0, 32'd9, 32'd4, 64'h0, 1'b0, 1'b0, 1);

    // Backpressure: result must sit still while the consumer stalls and new requests are ignored.
    v32 = 1'b1; op32 = 3'd1; s32 = 1'b0; a32 = 32'd10; b32 = 32'd20;
    @(posedge clock); #1;
    v32 = 1'b0;
    n = 0;
    while (!vo32 && n < 10) begin
      @(posedge clock); #1;
      n++;
    end
    checkOutput("bp_latency", 64'(n), 64'd1);
    v32 = 1'b1; op32 = 3'd3; a32 = 32'd7; b32 = 32'd7;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      checkOutput("bp_hold", {res32[31:0], 29'd0, vo32, rdy32, dz32 | il32}, {32'd30, 32'h4});
    end
    v32 = 1'b0; ri32 = 1'b1;
    @(posedge clock); #1;
    ri32 = 1'b0;
    checkOutput("bp_release", 64'({vo32, rdy32}), 64'b01);
    @(posedge clock); #1;
    checkOutput("bp_no_ghost", 64'({vo32, rdy32}), 64'b01);

    // Reset in the middle of a multiply must discard it completely.
    v32 = 1'b1; op32 = 3'd3; s32 = 1'b0; a32 = 32'd123; b32 = 32'd456;
    @(posedge clock); #1;
    v32 = 1'b0;
    repeat (10) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    checkOutput("midbusy_reset", {res32[31:0], 28'd0, rdy32, vo32, dz32, il32}, 64'h8);
    checkOutput("midbusy_reset_hi", 64'(res32[63:32]), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    checkOutput("post_reset_idle", 64'({vo32, rdy32}), 64'b01);
    applyStimulus("post_reset_add", 3'd1, 1'b0, 32'd2, 32'd3, 64'd5, 1'b0, 1'b0, 1);

    for (int i = 0; i < 1000; i++) begin
      applyStimulus8(3'($urandom_range(0, 7)), 1'($urandom), pick8(), pick8());
    end
    applyStimulus8(3'd4, 1'b1, 8'h80, 8'hFF);
    applyStimulus8(3'd3, 1'b1, 8'h80, 8'h80);
    applyStimulus8(3'd3, 1'b0, 8'hFF, 8'hFF);
    applyStimulus8(3'd4, 1'b0, 8'hFF, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
